uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one UART transmitter between `NUM_REQ` byte producers. It accepts a byte from the winning requester over a valid/ready handshake, issues a one-cycle `tx_start` with the byte to the transmitter, and tracks the transmitter's `tx_busy` until the frame completes. It then enforces an inter-frame idle gap and re-arbitrates. It sits between the application-side sources (fixed message buffers, loopback echo, debug dump) and the UART transmitter, all in the baud-clock domain.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `GAP_CYCLES`, 16: idle-high cycles enforced after each frame before the next `tx_start`; 0 is legal.
- `ACK_TIMEOUT`, 32: cycles to wait for `tx_busy` to rise after `tx_start` before aborting.
- `clk` in 1: clock, the divided baud-domain clock shared with the UART transmitter.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has a byte on `req_data[8i+7:8i]`.
- `req_data` in 8*NUM_REQ: packed request bytes.
- `req_last` in NUM_REQ: byte is the last of a burst (used only with `UART_SCHED_BURST_EN`).
- `req_ready` out NUM_REQ: one-hot, one-cycle accept pulse; the byte is consumed on that cycle.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_data` out 8: byte to transmit; stable from `tx_start` until `tx_busy` falls.
- `tx_busy` in 1: transmitter frame in progress (start, data and stop bits).
- `grant` out NUM_REQ: one-hot owner of the transmitter; 0 when idle.
- `sched_busy` out 1: FSM not in IDLE.
- `err_timeout` out 1: one-cycle pulse when `ACK_TIMEOUT` expires.

## Operation
States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP.
- **IDLE:**
  - If any `req_valid` is set, pick the winner by round-robin, searching from `last_grant+1` mod NUM_REQ upward with wrap.
  - Register `grant` and latch the winner's byte into `tx_data`, then go to ISSUE.
  - With no valid request, remain in IDLE.
- **ISSUE (exactly 1 cycle):**
  - `tx_start=1` and `req_ready[g]=1`.
  - `last_grant <= g`, timeout counter cleared.
  - Go to WAIT_ACK.
- **WAIT_ACK:**
  - `tx_busy=1` goes to WAIT_DONE.
  - If the counter reaches `ACK_TIMEOUT-1` without `tx_busy`, pulse `err_timeout`, clear `grant` and go to IDLE. The byte is dropped and not retried.
- **WAIT_DONE:** `tx_busy=0` goes to GAP, with the gap counter loaded to `GAP_CYCLES`.
- **GAP:**
  - Decrement the counter; at 0 go to IDLE and clear `grant`.
  - With `GAP_CYCLES=0`, GAP lasts exactly 1 cycle.
- **Requester contract:** `req_valid`/`req_data` must hold until `req_ready`. Deasserting `req_valid` before the accept is legal; the byte is simply not sent.
- **Arbitration:**
  - Arbitration looks only at `req_valid`.
  - A requester whose valid rises during a frame competes at the next IDLE.
  - Simultaneous requests resolve strictly by rotation, so no requester is granted twice while another valid requester waits.
- **Reset:**
  - All outputs are 0: `tx_start=0`, `tx_data=8'h00`, `req_ready=0`, `grant=0`, `sched_busy=0`, `err_timeout=0`.
  - State is IDLE and `last_grant=NUM_REQ-1`, so requester 0 wins first.
- **Reset mid-frame:** the FSM aborts immediately to IDLE and any burst lock is released. The transmitter must be reset by the same `rst_n`.

## Timing
- **Accept latency:** `req_valid` sampled high in IDLE at edge k gives `tx_start` and `req_ready` high for cycle k+1.
- **Minimum spacing** between consecutive `tx_start` pulses is 1 (ISSUE) + WAIT_ACK cycles + frame + `GAP_CYCLES`+1 cycles.
- `tx_start` never asserts while `tx_busy=1`.
- All outputs are registered; none is combinational from inputs.

## Configuration
- **`UART_SCHED_BURST_EN` defined:**
  - A granted requester whose accepted byte had `req_last=0` keeps the grant.
  - GAP then exits to ISSUE directly when that requester's `req_valid=1`; otherwise the FSM waits in GAP with the counter at 0.
  - The lock ends when a byte with `req_last=1` is accepted, or on timeout.
- **Undefined:** `req_last` is ignored and every byte is re-arbitrated.

## Structure
- **Shared package `uart_pkg`:** state enum (`SCHED_IDLE`..`SCHED_GAP`), `UART_BYTE_W=8`, default `GAP_CYCLES` and `ACK_TIMEOUT` constants shared with the TX/RX blocks.
- **Sub-module `uart_rr_pick`:** combinational round-robin chooser; inputs `req_valid` and `last_grant`, outputs one-hot winner and `any_valid`.

## Test plan
- **Single request:** after reset, `req_valid=4'b0001`, data 8'hA5, TX model busy 10 cycles. Expect `tx_start` one cycle after valid, `tx_data=8'hA5`, `req_ready[0]` coincident, and the next IDLE exactly `GAP_CYCLES+1` cycles after `tx_busy` falls.
- **Round-robin fairness:** all four requesters valid continuously, bytes 8'h10..8'h13. Grant order is 0,1,2,3,0,1; `tx_data` matches each owner.
- **Late arrival:** requester 2 valid while requester 1's frame is active. Requester 2 wins the next IDLE even though requester 0 became valid earlier, because rotation starts after 1.
- **Timeout:** TX model never raises `tx_busy`. `err_timeout` pulses exactly `ACK_TIMEOUT` cycles after `tx_start`, `grant` returns to 0, and the next request proceeds normally.
- **Reset mid-frame:** assert `rst_n=0` during WAIT_DONE. All outputs are 0 asynchronously; after release, requester 0 is granted first.
- **Burst mode** (`UART_SCHED_BURST_EN`): requester 1 sends 3 bytes with `req_last=0,0,1` while requester 0 is valid. Grant holds on 1 for all three bytes, then passes to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the TX scheduler state encoding, common to the TX/RX blocks.
package uart_pkg;

  localparam int UART_BYTE_W      = 8;
  localparam int UART_GAP_CYCLES  = 16;
  localparam int UART_ACK_TIMEOUT = 32;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_WAIT_ACK,
    SCHED_WAIT_DONE,
    SCHED_GAP
  } sched_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin chooser: first valid requester after last_grant, with wrap.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_valid
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    // Offsets 1..NUM_REQ put last_grant itself at the lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// Optional burst grant lock (req_last) is enabled with `define UART_SCHED_BURST_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = UART_GAP_CYCLES,
  parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_BYTE_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           sched_busy,
  output logic                           err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES);

  sched_state_t           state, state_nxt;
  logic [NUM_REQ-1:0]     pick_win, grant_nxt;
  logic                   any_valid, timeout;
  logic [IDX_W-1:0]       pick_idx, gnt_idx, gnt_idx_nxt, last_grant;
  logic [ACK_W-1:0]       ack_cnt, ack_cnt_nxt;
  logic [GAP_W-1:0]       gap_cnt, gap_cnt_nxt;
  logic [UART_BYTE_W-1:0] data_nxt;

  function automatic logic [UART_BYTE_W-1:0] byte_at(
    input logic [UART_BYTE_W*NUM_REQ-1:0] d,
    input logic [IDX_W-1:0]               idx
  );
    logic [UART_BYTE_W-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (IDX_W'(i) == idx) b = d[i*UART_BYTE_W +: UART_BYTE_W];
    return b;
  endfunction

  uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .winner    (pick_win),
    .any_valid (any_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_win[i]) pick_idx = IDX_W'(i);
  end

`ifdef UART_SCHED_BURST_EN
  logic burst_lock;

  // Lock follows req_last of the byte accepted during ISSUE; a timeout always drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   burst_lock <= 1'b0;
    else if (timeout)             burst_lock <= 1'b0;
    else if (state == SCHED_ISSUE) burst_lock <= !req_last[gnt_idx];
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    gnt_idx_nxt = gnt_idx;
    data_nxt    = tx_data;
    ack_cnt_nxt = ack_cnt;
    gap_cnt_nxt = gap_cnt;
    timeout     = 1'b0;
    case (state)
      SCHED_IDLE: begin
        if (any_valid) begin
          state_nxt   = SCHED_ISSUE;
          grant_nxt   = pick_win;
          gnt_idx_nxt = pick_idx;
          data_nxt    = byte_at(req_data, pick_idx);
          ack_cnt_nxt = '0;
        end
      end
      SCHED_ISSUE: begin
        state_nxt   = SCHED_WAIT_ACK;
        ack_cnt_nxt = ack_cnt + 1'b1;
      end
      SCHED_WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = SCHED_WAIT_DONE;
        end else if (ack_cnt >= ACK_LAST) begin
          state_nxt = SCHED_IDLE;
          grant_nxt = '0;
          timeout   = 1'b1;
        end else begin
          ack_cnt_nxt = ack_cnt + 1'b1;
        end
      end
      SCHED_WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt   = SCHED_GAP;
          gap_cnt_nxt = GAP_INIT;
        end
      end
      SCHED_GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
`ifdef UART_SCHED_BURST_EN
        else if (burst_lock) begin
          if (req_valid[gnt_idx]) begin
            state_nxt   = SCHED_ISSUE;
            data_nxt    = byte_at(req_data, gnt_idx);
            ack_cnt_nxt = '0;
          end
        end
`endif
        else begin
          state_nxt = SCHED_IDLE;
          grant_nxt = '0;
        end
      end
      default: state_nxt = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCHED_IDLE;
    else        state <= state_nxt;
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      gnt_idx     <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      ack_cnt     <= '0;
      gap_cnt     <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      req_ready   <= '0;
      sched_busy  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      grant       <= grant_nxt;
      gnt_idx     <= gnt_idx_nxt;
      ack_cnt     <= ack_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      tx_data     <= data_nxt;
      tx_start    <= (state_nxt == SCHED_ISSUE);
      req_ready   <= (state_nxt == SCHED_ISSUE) ? grant_nxt : '0;
      sched_busy  <= (state_nxt != SCHED_IDLE);
      err_timeout <= timeout;
      if (state == SCHED_ISSUE) last_grant <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester byte queues, busy-counter TX model, negedge monitor.
module tb_uart_tx_sched;

  localparam int NR    = 4;
  localparam int GAP   = 16;
  localparam int ACK   = 32;
  localparam int FRAME = 10;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [7:0]    dat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic [NR-1:0]   grant;
  logic            sched_busy;
  logic            err_timeout;

  int        n_checks = 0;
  int        n_fail   = 0;
  int        err_cnt  = 0;
  exp_t      sb[$];
  exp_t      mon_e;
  logic [NR-1:0] rdy_q = '0;
  logic [7:0] src_dat [NR][32];
  logic       src_lst [NR][32];
  int         src_len [NR];
  int         src_pos [NR];
  logic       tx_en = 1'b1;
  logic [4:0] busy_cnt;

  uart_tx_sched #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .sched_busy (sched_busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for FRAME cycles starting the cycle after tx_start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  busy_cnt <= '0;
    else if (tx_start && tx_en)  busy_cnt <= 5'(FRAME);
    else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 5'd1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input int g, input logic [7:0] d);
    exp_t t;
    t.gnt    = '0;
    t.gnt[g] = 1'b1;
    t.dat    = d;
    sb.push_back(t);
  endtask

  task automatic add_byte(input int s, input logic [7:0] d, input logic l);
    src_dat[s][src_len[s]] = d;
    src_lst[s][src_len[s]] = l;
    src_len[s]++;
  endtask

  task automatic flush_srcs();
    for (int i = 0; i < NR; i++) src_len[i] = src_pos[i];
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NR; i++) if (src_pos[i] != src_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Requesters: advance past a byte once the accept pulse has been seen, hold otherwise.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (rdy_q[i] && src_pos[i] < src_len[i]) src_pos[i]++;
      if (src_pos[i] < src_len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = src_dat[i][src_pos[i]];
        req_last[i]        = src_lst[i][src_pos[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    rdy_q = req_ready;
    if (rst_n && tx_start) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check_eq("start_grant", grant, mon_e.gnt);
        check_eq("start_data", tx_data, mon_e.dat);
        check_eq("start_ready", req_ready, mon_e.gnt);
        check_eq("start_tx_idle", tx_busy, 0);
      end
    end
    if (err_timeout) err_cnt++;
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tx_start"}, tx_start, 0);
    check_eq({tag, "_tx_data"}, tx_data, 0);
    check_eq({tag, "_req_ready"}, req_ready, 0);
    check_eq({tag, "_grant"}, grant, 0);
    check_eq({tag, "_sched_busy"}, sched_busy, 0);
    check_eq({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (tx_busy !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_busy_wait"}, tx_busy, lvl);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(sched_busy == 1'b0 && sb.size() == 0 && srcs_empty()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_sb_empty"}, sb.size(), 0);
    check_eq({tag, "_idle"}, sched_busy, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush_srcs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: accept latency, data, and GAP length after the frame.
    begin
      int n;
      exp_push(0, 8'hA5);
      add_byte(0, 8'hA5, 1'b1);
      @(negedge clk);
      check_eq("single_no_early_start", tx_start, 0);
      @(negedge clk);
      check_eq("single_start", tx_start, 1);
      check_eq("single_ready", req_ready, 4'b0001);
      check_eq("single_data", tx_data, 8'hA5);
      wait_busy(1'b1, "single_hi");
      wait_busy(1'b0, "single_lo");
      n = 0;
      @(negedge clk);
      while (grant != 0 && n < 100) begin
        n++;
        @(negedge clk);
      end
      check_eq("single_gap_len", n, GAP + 1);
      check_eq("single_idle_after_gap", sched_busy, 0);
    end

    // Fairness: all four requesters valid from reset.
    pulse_reset();
    exp_push(0, 8'h10); exp_push(1, 8'h11); exp_push(2, 8'h12);
    exp_push(3, 8'h13); exp_push(0, 8'h14); exp_push(1, 8'h15);
    add_byte(0, 8'h10, 1'b1); add_byte(0, 8'h14, 1'b1);
    add_byte(1, 8'h11, 1'b1); add_byte(1, 8'h15, 1'b1);
    add_byte(2, 8'h12, 1'b1); add_byte(3, 8'h13, 1'b1);
    wait_idle("rr");

    // Late arrival: rotation after requester 1 reaches 2 before 0.
    exp_push(1, 8'h21); exp_push(2, 8'h22); exp_push(0, 8'h20);
    add_byte(1, 8'h21, 1'b1);
    wait_busy(1'b1, "late");
    add_byte(0, 8'h20, 1'b1);
    repeat (3) @(negedge clk);
    add_byte(2, 8'h22, 1'b1);
    wait_idle("late");

    // Timeout: transmitter never acknowledges.
    begin
      int n;
      tx_en = 1'b0;
      exp_push(3, 8'h33);
      add_byte(3, 8'h33, 1'b1);
      n = 0;
      while (!tx_start && n < 100) begin
        @(negedge clk);
        n++;
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!err_timeout && n < 200);
      check_eq("timeout_delay", n, ACK);
      check_eq("timeout_grant_clr", grant, 0);
      @(negedge clk);
      check_eq("timeout_pulse_width", err_timeout, 0);
      tx_en = 1'b1;
      exp_push(1, 8'h44);
      add_byte(1, 8'h44, 1'b1);
      wait_idle("post_timeout");
    end

    // Reset in WAIT_DONE: asynchronous clear, then requester 0 first.
    exp_push(2, 8'h55);
    add_byte(2, 8'h55, 1'b1);
    wait_busy(1'b1, "midrst");
    @(negedge clk);
    @(negedge clk);
    check_eq("midrst_pre_grant", grant, 4'b0100);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    flush_srcs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_push(0, 8'h60); exp_push(2, 8'h66);
    add_byte(2, 8'h66, 1'b1);
    add_byte(0, 8'h60, 1'b1);
    wait_idle("midrst_after");

`ifdef UART_SCHED_BURST_EN
    // Burst: requester 1 keeps the grant until req_last, then 0 is served.
    begin
      int n;
      pulse_reset();
      exp_push(1, 8'hB0); exp_push(1, 8'hB1); exp_push(1, 8'hB2); exp_push(0, 8'hA0);
      add_byte(1, 8'hB0, 1'b0); add_byte(1, 8'hB1, 1'b0); add_byte(1, 8'hB2, 1'b1);
      n = 0;
      while (!tx_start && n < 100) begin
        @(negedge clk);
        n++;
      end
      add_byte(0, 8'hA0, 1'b1);
      wait_idle("burst");
    end
`endif

    check_eq("err_pulse_count", err_cnt, 1);
    check_eq("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
